// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: control FSM for a multicycle RV32I subset core
// (lw, sw, R-type, I-type, beq, jal) sharing one memory port between
// instruction fetch and data access.
//
// Ports:
//   clk, reset            clock; asynchronous active-high reset
//   op, funct3, funct7    instruction fields (funct7 is instruction bit 30)
//   zero                  ALU zero flag, used only in BEQ
//   mem_ready             memory handshake, used only in the wait states
//   PCWrite, IRWrite,     datapath register / memory enables
//   MemWrite, RegWrite
//   AdrSrc, ResultSrc,    datapath mux selects
//   ALUSrcA, ALUSrcB
//   ImmSrc                immediate format, decoded from op in every state
//   ALUControl            ALU operation
//   illegal_op, mem_err   one-cycle error pulses
//   state                 current state, for debug
module multicycle_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ImmSrc,
  output logic [2:0] ALUControl,
  output logic       illegal_op,
  output logic       mem_err,
  output logic [3:0] state
);

  // Counter only needs to reach MEM_TIMEOUT-1.
  localparam int unsigned CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_ALUWB    = 4'd7,
    S_EXECI    = 4'd8,
    S_JAL      = 4'd9,
    S_BEQ      = 4'd10
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic       pc_we, ir_we, mem_we, rf_we, ill, err;
  logic [1:0] alu_op;
  logic       wait_st, stalled, timeout;

  // State and wait counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // A wait state stalls while memory is not ready; the last allowed stall
  // cycle aborts the instruction instead of waiting again.
  always_comb begin
    wait_st = (state_q == S_FETCH) || (state_q == S_MEMREAD) || (state_q == S_MEMWRITE);
    stalled = wait_st && !mem_ready;
    timeout = stalled && (MEM_TIMEOUT != 0) && (cnt_q == CNT_W'(MEM_TIMEOUT - 1));
  end

  // Next state, Moore outputs and timeout override.
  always_comb begin
    state_d   = state_q;
    pc_we     = 1'b0;
    ir_we     = 1'b0;
    mem_we    = 1'b0;
    rf_we     = 1'b0;
    ill       = 1'b0;
    err       = 1'b0;
    alu_op    = 2'b00;
    AdrSrc    = 1'b0;
    ResultSrc = 2'b00;
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;

    case (state_q)
      S_FETCH: begin
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        ir_we     = mem_ready;
        pc_we     = mem_ready;
        if (mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECR;
          OP_I:         state_d = S_EXECI;
          OP_JAL:       state_d = S_JAL;
          OP_BEQ:       state_d = S_BEQ;
          default: begin
            state_d = S_FETCH;
            ill     = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        state_d = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        AdrSrc = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc = 2'b01;
        rf_we     = 1'b1;
        state_d   = S_FETCH;
      end
      S_MEMWRITE: begin
        AdrSrc = 1'b1;
        mem_we = 1'b1;
        if (mem_ready) state_d = S_FETCH;
      end
      S_EXECR: begin
        ALUSrcA = 2'b10;
        alu_op  = 2'b10;
        state_d = S_ALUWB;
      end
      S_EXECI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        alu_op  = 2'b10;
        state_d = S_ALUWB;
      end
      S_JAL: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b10;
        pc_we   = 1'b1;
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        rf_we   = 1'b1;
        state_d = S_FETCH;
      end
      S_BEQ: begin
        ALUSrcA = 2'b10;
        alu_op  = 2'b01;
        pc_we   = zero;
        state_d = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase

    if (timeout) begin
      state_d = S_FETCH;
      err     = 1'b1;
      mem_we  = 1'b0;
      ir_we   = 1'b0;
      pc_we   = 1'b0;
    end

    // Count only while stalling in place; any state change or abort clears.
    cnt_d = '0;
    if (stalled && !timeout && (MEM_TIMEOUT != 0)) cnt_d = cnt_q + CNT_W'(1);
  end

  // ALU operation from ALUOp and the function fields.
  always_comb begin
    ALUControl = 3'b000;
    case (alu_op)
      2'b01: ALUControl = 3'b001;
      2'b10: begin
        case (funct3)
          3'b000:  ALUControl = (op[5] & funct7) ? 3'b001 : 3'b000;
          3'b010:  ALUControl = 3'b101;
          3'b110:  ALUControl = 3'b011;
          3'b111:  ALUControl = 3'b010;
          default: ALUControl = 3'b000;
        endcase
      end
      default: ALUControl = 3'b000;
    endcase
  end

  // Immediate format follows the opcode regardless of state.
  always_comb begin
    case (op)
      OP_SW:   ImmSrc = 2'b01;
      OP_BEQ:  ImmSrc = 2'b10;
      OP_JAL:  ImmSrc = 2'b11;
      default: ImmSrc = 2'b00;
    endcase
  end

  // Enables and pulses are held low for the whole time reset is asserted.
  assign PCWrite    = pc_we  & ~reset;
  assign IRWrite    = ir_we  & ~reset;
  assign MemWrite   = mem_we & ~reset;
  assign RegWrite   = rf_we  & ~reset;
  assign illegal_op = ill    & ~reset;
  assign mem_err    = err    & ~reset;
  assign state      = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: scoreboard bench for multicycle_ctrl. Each cycle the
// expected output vector is pushed when inputs are driven and popped and
// compared at the following negative clock edge.
`timescale 1ns/1ps
module tb_multicycle_ctrl;

  localparam int unsigned TO = 4;

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMREAD  = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWRITE = 4'd5;
  localparam logic [3:0] S_EXECR    = 4'd6;
  localparam logic [3:0] S_ALUWB    = 4'd7;
  localparam logic [3:0] S_EXECI    = 4'd8;
  localparam logic [3:0] S_JAL      = 4'd9;
  localparam logic [3:0] S_BEQ      = 4'd10;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_BAD = 7'b1111111;

  logic       clk, reset;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7, zero, mem_ready;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [2:0] ALUControl;
  logic       illegal_op, mem_err;
  logic [3:0] state;

  typedef struct packed {
    logic [3:0] st;
    logic       pcw;
    logic       adr;
    logic       memw;
    logic       irw;
    logic       regw;
    logic [1:0] rs;
    logic [1:0] sa;
    logic [1:0] sb;
    logic [1:0] imm;
    logic [2:0] aluc;
    logic       ill;
    logic       merr;
  } obs_t;

  obs_t  obs;
  obs_t  exp_q[$];
  int    checks;
  int    errors;
  int    cyc;
  string tname;
  logic [1:0] imm_exp;
  logic [2:0] alu_exp;

  multicycle_ctrl #(.MEM_TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7(funct7),
    .zero(zero), .mem_ready(mem_ready), .PCWrite(PCWrite), .AdrSrc(AdrSrc),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .RegWrite(RegWrite),
    .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ImmSrc(ImmSrc), .ALUControl(ALUControl), .illegal_op(illegal_op),
    .mem_err(mem_err), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign obs = {state, PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
                ALUSrcA, ALUSrcB, ImmSrc, ALUControl, illegal_op, mem_err};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%06h exp=%06h", tag, got, exp);
    end
  endtask

  // Expected vector: mux selects from the per-state table, enables as given.
  function automatic obs_t mk_exp(input logic [3:0] st, input logic pcw, input logic irw,
                                  input logic memw, input logic regw, input logic ill,
                                  input logic merr);
    obs_t e;
    e      = '0;
    e.st   = st;
    e.pcw  = pcw;
    e.irw  = irw;
    e.memw = memw;
    e.regw = regw;
    e.ill  = ill;
    e.merr = merr;
    e.imm  = imm_exp;
    case (st)
      S_FETCH:    begin e.sb = 2'b10; e.rs = 2'b10; end
      S_DECODE:   begin e.sa = 2'b01; e.sb = 2'b01; end
      S_MEMADR:   begin e.sa = 2'b10; e.sb = 2'b01; end
      S_MEMREAD:  e.adr = 1'b1;
      S_MEMWB:    e.rs = 2'b01;
      S_MEMWRITE: e.adr = 1'b1;
      S_EXECR:    begin e.sa = 2'b10; e.aluc = alu_exp; end
      S_EXECI:    begin e.sa = 2'b10; e.sb = 2'b01; e.aluc = alu_exp; end
      S_JAL:      begin e.sa = 2'b01; e.sb = 2'b10; end
      S_BEQ:      begin e.sa = 2'b10; e.aluc = 3'b001; end
      default:    e.rs = 2'b00;
    endcase
    return e;
  endfunction

  task automatic compare_next(input logic [3:0] st);
    obs_t e;
    e = exp_q.pop_front();
    check_eq($sformatf("%s.c%0d.s%0d", tname, cyc, st), 32'(obs), 32'(e));
    cyc++;
  endtask

  // One clock cycle: drive, push expectation, compare mid-cycle, advance.
  task automatic step(input logic rdy, input logic z, input logic [3:0] st,
                      input logic pcw, input logic irw, input logic memw,
                      input logic regw, input logic ill, input logic merr);
    mem_ready = rdy;
    zero      = z;
    exp_q.push_back(mk_exp(st, pcw, irw, memw, regw, ill, merr));
    @(negedge clk);
    compare_next(st);
    @(posedge clk);
    #1;
  endtask

  task automatic start(input string n, input logic [6:0] o, input logic [2:0] f3,
                       input logic f7, input logic [1:0] imm, input logic [2:0] alu);
    tname   = n;
    cyc     = 0;
    op      = o;
    funct3  = f3;
    funct7  = f7;
    imm_exp = imm;
    alu_exp = alu;
  endtask

  task automatic fetch_ok();
    step(1'b1, 1'b0, S_FETCH, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic decode_ok();
    step(1'b1, 1'b1, S_DECODE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic alu_instr(input string n, input logic [6:0] o, input logic [2:0] f3,
                           input logic f7, input logic [2:0] alu);
    start(n, o, f3, f7, 2'b00, alu);
    fetch_ok();
    decode_ok();
    step(1'b1, 1'b0, (o == OP_R) ? S_EXECR : S_EXECI, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, S_ALUWB, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1;
    mem_ready = 1'b1;
    zero = 1'b0;
    start("reset", OP_LW, 3'b000, 1'b0, 2'b00, 3'b000);
    #2;
    // FETCH with mem_ready=1 held in reset: enables must stay low.
    step(1'b1, 1'b0, S_FETCH, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;

    start("lw", OP_LW, 3'b010, 1'b0, 2'b00, 3'b000);
    fetch_ok();
    decode_ok();
    step(1'b1, 1'b0, S_MEMADR,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, S_MEMREAD, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, S_MEMWB,   1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

    start("sw", OP_SW, 3'b010, 1'b0, 2'b01, 3'b000);
    step(1'b0, 1'b0, S_FETCH, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, S_FETCH, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    fetch_ok();
    decode_ok();
    step(1'b1, 1'b0, S_MEMADR, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++)
      step(1'b0, 1'b0, S_MEMWRITE, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    // Fourth wait cycle is the timeout cycle, but ready wins.
    step(1'b1, 1'b0, S_MEMWRITE, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

    start("beq_t", OP_BEQ, 3'b000, 1'b0, 2'b10, 3'b001);
    fetch_ok();
    decode_ok();
    step(1'b1, 1'b1, S_BEQ, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    start("beq_nt", OP_BEQ, 3'b000, 1'b0, 2'b10, 3'b001);
    fetch_ok();
    decode_ok();
    step(1'b1, 1'b0, S_BEQ, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    alu_instr("sub",  OP_R, 3'b000, 1'b1, 3'b001);
    alu_instr("add",  OP_R, 3'b000, 1'b0, 3'b000);
    alu_instr("slt",  OP_R, 3'b010, 1'b0, 3'b101);
    alu_instr("or",   OP_R, 3'b110, 1'b0, 3'b011);
    alu_instr("addi", OP_I, 3'b000, 1'b1, 3'b000);
    alu_instr("andi", OP_I, 3'b111, 1'b0, 3'b010);

    start("illegal", OP_BAD, 3'b000, 1'b0, 2'b00, 3'b000);
    fetch_ok();
    step(1'b1, 1'b0, S_DECODE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    start("jal", OP_JAL, 3'b000, 1'b0, 2'b11, 3'b000);
    fetch_ok();
    decode_ok();
    step(1'b1, 1'b0, S_JAL,   1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, S_ALUWB, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

    start("lw_to", OP_LW, 3'b010, 1'b0, 2'b00, 3'b000);
    fetch_ok();
    decode_ok();
    step(1'b1, 1'b0, S_MEMADR, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++)
      step(1'b0, 1'b0, S_MEMREAD, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, S_MEMREAD, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    start("sw_to", OP_SW, 3'b010, 1'b0, 2'b01, 3'b000);
    fetch_ok();
    decode_ok();
    step(1'b1, 1'b0, S_MEMADR, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++)
      step(1'b0, 1'b0, S_MEMWRITE, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, S_MEMWRITE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    start("fetch_to", OP_LW, 3'b010, 1'b0, 2'b00, 3'b000);
    for (int i = 0; i < 3; i++)
      step(1'b0, 1'b0, S_FETCH, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, S_FETCH, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    // Counter was cleared by the abort: three more stalls must not error.
    for (int i = 0; i < 3; i++)
      step(1'b0, 1'b0, S_FETCH, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    fetch_ok();
    decode_ok();
    step(1'b1, 1'b0, S_MEMADR,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, S_MEMREAD, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, S_MEMWB,   1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

    // Reset asserted asynchronously partway through EXECR.
    start("rst_exec", OP_R, 3'b000, 1'b1, 2'b00, 3'b001);
    fetch_ok();
    decode_ok();
    mem_ready = 1'b1;
    #2;
    exp_q.push_back(mk_exp(S_EXECR, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    compare_next(S_EXECR);
    reset = 1'b1;
    #1;
    exp_q.push_back(mk_exp(S_FETCH, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    compare_next(S_FETCH);
    @(posedge clk);
    #1;
    reset = 1'b0;

    start("post_rst", OP_JAL, 3'b000, 1'b0, 2'b11, 3'b000);
    fetch_ok();
    decode_ok();
    step(1'b1, 1'b0, S_JAL, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Control FSM for the multicycle RV32I core subset: lw, sw, R-type ALU, I-type ALU, beq, jal.
- Replaces the single-cycle ctrl decoder when instruction and data share one memory port.
- Sequences the shared ALU and memory over several cycles and drives the datapath enables and muxes.
- Waits on a memory-ready handshake, with a bounded timeout.

Parameters:
- MEM_TIMEOUT, 16: maximum consecutive cycles spent waiting on mem_ready in one wait state. 0 disables the timeout.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high; forces the FSM to FETCH and clears the timeout counter.
- op  in  7  opcode from the instruction register; stable from DECODE onward.
- funct3  in  3  instruction funct3.
- funct7  in  1  instruction bit 30.
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory access completes this cycle.
- PCWrite  out  1  PC register enable.
- AdrSrc  out  1  memory address select: 0 = PC, 1 = ALUOut.
- MemWrite  out  1  memory write strobe.
- IRWrite  out  1  instruction register enable.
- RegWrite  out  1  register file write enable.
- ResultSrc  out  2  result mux: 00 = ALUOut, 01 = data, 10 = ALU result.
- ALUSrcA  out  2  ALU A select: 00 = PC, 01 = OldPC, 10 = rs1.
- ALUSrcB  out  2  ALU B select: 00 = rs2, 01 = imm, 10 = constant 4.
- ImmSrc  out  2  immediate format.
- ALUControl  out  3  ALU operation: 000 add, 001 sub, 010 and, 011 or, 101 slt.
- illegal_op  out  1  one-cycle pulse on an unsupported opcode.
- mem_err  out  1  one-cycle pulse on a memory timeout.
- state  out  4  current state, for debug.

Behaviour:
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, ALUWB=7, EXECI=8, JAL=9, BEQ=10.
- Reset: state=FETCH and timeout counter=0 asynchronously. While reset=1, PCWrite, IRWrite, MemWrite, RegWrite, illegal_op and mem_err are forced to 0. Reset mid-instruction abandons that instruction.
- Outputs are Moore, decoded from state, except where mem_ready or zero is stated. Unlisted outputs default to 0.
- ImmSrc is purely combinational from op in every state: lw/I-type 00, sw 01, beq 10, jal 11, others 00.
- ALUOp mapping:
  - ALUOp 00 gives ALUControl=000.
  - ALUOp 01 gives ALUControl=001.
  - ALUOp 10 decodes funct3: 000 gives 001 when op[5]&funct7=1, else 000; 010 gives 101; 110 gives 011; 111 gives 010; others give 000.
- FETCH: AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp 00, ResultSrc=10, IRWrite=PCWrite=mem_ready. Next state is DECODE if mem_ready, else FETCH.
- DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp 00 (computes the branch target). Next state:
  - lw (0000011) or sw (0100011) go to MEMADR.
  - 0110011 goes to EXECR.
  - 0010011 goes to EXECI.
  - 1101111 goes to JAL.
  - 1100011 goes to BEQ.
  - Any other opcode goes to FETCH with illegal_op=1 for that cycle.
- MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp 00. Next state is MEMREAD if op=lw, else MEMWRITE.
- MEMREAD: AdrSrc=1. Next state is MEMWB when mem_ready, else hold.
- MEMWB: ResultSrc=01, RegWrite=1. Next state FETCH.
- MEMWRITE: AdrSrc=1, MemWrite=1, held high while waiting. Next state is FETCH when mem_ready, else hold.
- EXECR: ALUSrcA=10, ALUSrcB=00, ALUOp 10. Next state ALUWB.
- EXECI: ALUSrcA=10, ALUSrcB=01, ALUOp 10. Next state ALUWB.
- JAL: ALUSrcA=01, ALUSrcB=10, ALUOp 00, ResultSrc=00, PCWrite=1. Next state ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1. Next state FETCH.
- BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp 01, ResultSrc=00, PCWrite=zero. Next state FETCH.
- Timeout counter:
  - Increments on each cycle spent in FETCH, MEMREAD or MEMWRITE with mem_ready=0.
  - Clears on any state change.
  - When MEM_TIMEOUT>0 and the counter reaches MEM_TIMEOUT-1 with mem_ready still 0, mem_err=1 for that cycle. The FSM then goes to FETCH and the counter clears.
  - In that abort cycle, MemWrite, IRWrite and PCWrite are forced to 0.
- mem_ready=1 on the timeout cycle: the normal transition wins and mem_err=0.
- Simultaneous events: mem_ready is ignored outside the three wait states. zero is ignored outside BEQ.
- Instruction latencies at mem_ready=1 throughout: lw 5 cycles, sw 4, R-type/I-type 4, jal 4, beq 3.

Test Plan:
- Reset then lw (op=0000011) with mem_ready=1 -> state sequence 0,1,2,3,4,0. RegWrite=1 and ResultSrc=01 only in state 4. ImmSrc=00.
- sw with mem_ready low for 3 cycles in MEMWRITE -> MemWrite=1 for 4 cycles, then FETCH. Stalled FETCH keeps IRWrite=0.
- beq with zero=1, then again with zero=0 -> PCWrite=1 in BEQ only in the first run. ALUControl=001 and ImmSrc=10 in both.
- R-type funct3=000: funct7=1 -> ALUControl=001; funct7=0 -> 000. funct3=010 -> 101. Each followed by ALUWB with RegWrite=1.
- op=1111111 -> DECODE to FETCH, illegal_op pulse of 1 cycle, no RegWrite/MemWrite. jal -> PCWrite in JAL, ImmSrc=11, then ALUWB.
- MEM_TIMEOUT=4, mem_ready=0 in MEMREAD -> mem_err on the 4th wait cycle, next state FETCH. Assert reset mid-EXECR -> state=0 immediately, enables low.
